// File: rtl/code_loader.sv
// code_loader: boot sequencer that packs host bytes little-endian into 16-bit words,
//   writes them to code memory from address 0 upward, then releases the core via run.
// Latency: high-byte handshake in cycle N -> code_w_en in cycle N+1; run rises
//   HOLD_CYCLES+1 edges after load_end (or HOLD_CYCLES+1 edges after the final write).
// Backpressure: byte_ready only in LO/HI and never in a load_start/load_end cycle;
//   the WRITE cycle and a full memory stall the host.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load_start, load_end     single-cycle control pulses from the host
//   byte_in/valid/ready      host byte stream (valid/ready)
//   code_w_en/addr_in/in     code memory write port
//   run, busy                core release, loader activity
//   word_count, err          words written this load, sticky odd-byte error
module code_loader #(
    parameter int ADDR_WIDTH  = 9,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  code_w_en,
    output logic [ADDR_WIDTH-1:0] code_addr_in,
    output logic [15:0]           code_in,
    output logic                  run,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err
);

    // Hold counter only needs to reach HOLD_CYCLES-1.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WRITE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_data;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_err;
    logic [HW-1:0]         r_hold;
    logic                  w_xfer;
    logic                  w_addr_last;

    assign byte_ready  = ((r_state == S_LO) || (r_state == S_HI)) & ~load_start & ~load_end;
    assign w_xfer      = byte_valid & byte_ready;
    assign w_addr_last = &r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (load_start) begin
            w_next = S_LO;
        end else begin
            case (r_state)
                S_LO: begin
                    if (load_end)    w_next = S_HOLD;
                    else if (w_xfer) w_next = S_HI;
                end
                S_HI: begin
                    if (load_end)    w_next = S_HOLD;
                    else if (w_xfer) w_next = S_WRITE;
                end
                // Writing the top address fills memory; stop accepting bytes.
                S_WRITE: w_next = w_addr_last ? S_HOLD : S_LO;
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) w_next = S_RUN;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_hold <= '0;
        end else begin
            if (load_start) begin
                r_addr <= '0;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end else begin
                case (r_state)
                    S_LO: begin
                        if (w_xfer) r_data[7:0] <= byte_in;
                    end
                    S_HI: begin
                        // Ending on a lone low byte drops it and flags the host.
                        if (load_end)    r_err <= 1'b1;
                        else if (w_xfer) r_data[15:8] <= byte_in;
                    end
                    S_WRITE: begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            // Counter is zero on HOLD entry and counts its cycles there.
            if ((r_state == S_HOLD) && !load_start) r_hold <= r_hold + 1'b1;
            else                                    r_hold <= '0;
        end
    end

    assign code_w_en    = (r_state == S_WRITE);
    assign run          = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE) && (r_state != S_RUN);
    assign code_addr_in = r_addr;
    assign code_in      = r_data;
    assign word_count   = r_cnt;
    assign err          = r_err;

endmodule
